mem_edit_ctrl: RTL and testbench

Key-driven sequencer for the 16x8 synchronous RAM (one-cycle registered read, old-data read-during-write). It synchronizes and debounces the four active-low push-buttons and turns each clean press into one RAM transaction: an address step or a read-modify-write increment/decrement of the selected byte. It sits between the board keys and the RAM, and drives the address and data that the hex display path shows.

---
 rtl/mem_edit_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mem_edit_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_edit_ctrl.sv
// mem_edit_ctrl
//   Key-driven editor for a 16x8 synchronous RAM (registered read, old data
//   on read-during-write). The four active-low push-buttons are synchronized
//   and debounced. Each clean single-key press becomes one RAM transaction:
//   an address step, or a read-modify-write increment/decrement of the byte
//   at the current address.
//
//   Optional feature macro: MEM_EDIT_AUTOREPEAT_EN
//     When defined, holding a data key repeats the data op every
//     REPEAT_CYCLES cycles. When undefined, every press gives exactly one op.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed before the debounced keys change (>=2)
//   REPEAT_CYCLES    auto-repeat period, used only with the macro (>=4)
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   KEY    in   [3:0] raw push-buttons, active-low, asynchronous to clk
//   dout   in   [7:0] RAM read data (mem[a], registered one cycle)
//   a      out  [3:0] RAM address, registered
//   din    out  [7:0] RAM write data, registered
//   we     out  RAM write enable, one-cycle pulse
//   busy   out  high while a transaction is in flight (RD, WR, SETTLE)
//
// State      | meaning
// -----------+---------------------------------------------------------
// IDLE       | all keys released, waiting for a single-key press
// RD         | address held, dout carries mem[a]; din/we loaded on exit
// WR         | we high for this one cycle
// SETTLE     | one cycle so dout reflects the updated mem[a]
// WAIT_REL   | wait for all keys released (auto-repeat fires from here)

module mem_edit_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [7:0] dout,
    output logic [3:0] a,
    output logic [7:0] din,
    output logic       we,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR       = 3'd2,
        SETTLE   = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 4) begin : g_param_check
            $error("mem_edit_ctrl: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 4");
        end
    endgenerate

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LOAD  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_FIRST = DB_W'(DEBOUNCE_CYCLES - 2);

    state_t state, state_n;

    logic [3:0]      sync1, sync2, p_q;
    logic [3:0]      p;
    logic [3:0]      k;
    logic [DB_W-1:0] db_cnt;
    logic            k_onehot;
    logic            op_dec;
    logic            rep_fire;

    // Input path: two-flop synchronizer on the inverted (active-high) keys
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
            p_q   <= 4'b0000;
        end else begin
            sync1 <= ~KEY;
            sync2 <= sync1;
            p_q   <= sync2;
        end
    end

    assign p = sync2;

    // Debounce down-counter. The cycle in which p takes a new value already
    // counts as its first stable cycle, hence the DB_FIRST reload; k takes p
    // on the DEBOUNCE_CYCLES-th consecutive stable cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            k      <= 4'b1111;
            db_cnt <= DB_LOAD;
        end else if (p == k) begin
            db_cnt <= DB_LOAD;
        end else if (p != p_q) begin
            db_cnt <= DB_FIRST;
        end else if (db_cnt == '0) begin
            k      <= p;
            db_cnt <= DB_LOAD;
        end else begin
            db_cnt <= db_cnt - 1'b1;
        end
    end

    // IDLE is only reached with k == 0, so any one-hot k seen there is a
    // fresh press from all-released.
    assign k_onehot = (k != 4'b0000) && ((k & (k - 4'd1)) == 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_REL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (k != 4'b0000) begin
                    if (!k_onehot)
                        state_n = WAIT_REL;
                    else if (k[0] || k[1])
                        state_n = RD;
                    else
                        state_n = SETTLE;
                end
            end
            RD:       state_n = WR;
            WR:       state_n = SETTLE;
            SETTLE:   state_n = WAIT_REL;
            WAIT_REL: begin
                if (k == 4'b0000)
                    state_n = IDLE;
                else if (rep_fire)
                    state_n = RD;
            end
            default:  state_n = WAIT_REL;
        endcase
    end

    assign busy = (state == RD) || (state == WR) || (state == SETTLE);

    // Datapath. The op direction is latched at the press so key activity
    // during the transaction cannot change it.
    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= 4'h0;
            din    <= 8'h00;
            we     <= 1'b0;
            op_dec <= 1'b0;
        end else begin
            we <= (state == RD);
            if (state == RD)
                din <= op_dec ? (dout - 8'd1) : (dout + 8'd1);
            if (state == IDLE && k_onehot) begin
                op_dec <= k[1];
                if (k[2])
                    a <= a + 4'd1;
                else if (k[3])
                    a <= a - 4'd1;
            end
        end
    end

`ifdef MEM_EDIT_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES);
    localparam logic [RP_W-1:0] RP_LOAD = RP_W'(REPEAT_CYCLES - 1);

    logic [RP_W-1:0] rep_cnt;
    logic [3:0]      rep_key;
    logic            rep_arm;
    logic            rep_run;

    // The period runs from WAIT_REL entry of the initial op, then from each
    // fire; it keeps counting through the repeated transactions so repeats
    // are exactly REPEAT_CYCLES apart.
    assign rep_fire = (state == WAIT_REL) && rep_arm && (k == rep_key) && (rep_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt <= RP_LOAD;
            rep_key <= 4'b0000;
            rep_arm <= 1'b0;
            rep_run <= 1'b0;
        end else begin
            if (state == IDLE && k_onehot) begin
                rep_key <= k;
                rep_arm <= k[0] | k[1];
                rep_run <= 1'b0;
            end else if (rep_fire) begin
                rep_run <= 1'b1;
            end else if (state == WAIT_REL && k != rep_key) begin
                rep_arm <= 1'b0;
            end

            if ((state == SETTLE && !rep_run) || rep_fire)
                rep_cnt <= RP_LOAD;
            else if (rep_cnt != '0)
                rep_cnt <= rep_cnt - 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_mem_edit_ctrl.sv
// Directed bench for mem_edit_ctrl with a behavioural 16x8 RAM
// (registered read, old data on read-during-write).
module tb_mem_edit_ctrl;

    localparam int DB = 4;
    localparam int RP = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] KEY = 4'hF;
    logic [7:0] dout;
    logic [3:0] a;
    logic [7:0] din;
    logic       we;
    logic       busy;

    logic [7:0] mem [16];
    int         vectors = 0;
    int         errors  = 0;
    int         wr_count = 0;

    mem_edit_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
        .clk   (clk),
        .reset (reset),
        .KEY   (KEY),
        .dout  (dout),
        .a     (a),
        .din   (din),
        .we    (we),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) begin
            mem[a]   <= din;
            wr_count <= wr_count + 1;
        end
        dout <= mem[a];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic release_keys;
        KEY = 4'hF;
        repeat (14) tick();
    endtask

    // Press one data key from IDLE; check latency, pulse shape and readback.
    task automatic do_data_op(input int idx, input logic [3:0] ea, input logic [7:0] ed);
        int n;
        int w0;
        w0 = wr_count;
        KEY[idx] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (busy !== 1'b1 && n < 40);
        vectors++;
        if (n !== 7) begin errors++; $display("FAIL data_latency key%0d: got %0d cycles, want 7", idx, n); end
        vectors++;
        if (we !== 1'b0) begin errors++; $display("FAIL rd_we key%0d: got %b, want 0", idx, we); end
        tick();
        vectors++;
        if (we !== 1'b1 || a !== ea || din !== ed) begin
            errors++;
            $display("FAIL wr_cycle key%0d: we=%b a=%h din=%h, want we=1 a=%h din=%h", idx, we, a, din, ea, ed);
        end
        tick();
        vectors++;
        if (we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL settle key%0d: we=%b busy=%b, want we=0 busy=1", idx, we, busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || dout !== ed) begin
            errors++;
            $display("FAIL post_op key%0d: busy=%b dout=%h, want busy=0 dout=%h", idx, busy, dout, ed);
        end
        vectors++;
        if (wr_count - w0 !== 1) begin errors++; $display("FAIL write_count key%0d: got %0d, want 1", idx, wr_count - w0); end
        release_keys();
    endtask

    task automatic do_addr_op(input int idx, input logic [3:0] ea);
        int n;
        int w0;
        logic [3:0] a0;
        w0 = wr_count;
        a0 = a;
        KEY[idx] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (a === a0 && n < 40);
        vectors++;
        if (n !== 7 || a !== ea || busy !== 1'b1) begin
            errors++;
            $display("FAIL addr_step key%0d: cycles=%0d a=%h busy=%b, want 7 a=%h busy=1", idx, n, a, busy, ea);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || wr_count !== w0) begin
            errors++;
            $display("FAIL addr_nowrite key%0d: busy=%b writes=%0d, want busy=0 writes=0", idx, busy, wr_count - w0);
        end
        release_keys();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        KEY = 4'hF;
        repeat (3) tick();
        vectors++;
        if (a !== 4'h0 || din !== 8'h00 || we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: a=%h din=%h we=%b busy=%b, want 0 00 0 0", a, din, we, busy);
        end
        reset = 1'b0;
        repeat (12) tick();
        vectors++;
        if (a !== 4'h0 || busy !== 1'b0 || wr_count !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: a=%h busy=%b writes=%0d, want 0 0 0", a, busy, wr_count);
        end
    endtask

    task automatic test_data_inc;
        do_data_op(0, 4'h0, 8'h01);
    endtask

    task automatic test_addr_wrap_and_dec;
        do_addr_op(3, 4'hF);
        do_data_op(1, 4'hF, 8'hFF);
        vectors++;
        if (mem[15] !== 8'hFF) begin errors++; $display("FAIL mem15: got %h, want ff", mem[15]); end
    endtask

    task automatic test_bounce;
        int w0;
        w0 = wr_count;
        for (int i = 0; i < 20; i++) begin
            KEY[2] = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        KEY[2] = 1'b0;
        repeat (100) tick();
        vectors++;
        if (a !== 4'h0 || wr_count !== w0) begin
            errors++;
            $display("FAIL bounce: a=%h writes=%0d, want a=0 writes=0", a, wr_count - w0);
        end
        release_keys();
    endtask

    task automatic test_multi_key;
        int w0;
        logic seen_busy;
        w0 = wr_count;
        seen_busy = 1'b0;
        KEY = 4'b1010;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        vectors++;
        if (a !== 4'h0 || wr_count !== w0 || seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL multi_key: a=%h writes=%0d busy_seen=%b, want 0 0 0", a, wr_count - w0, seen_busy);
        end
        release_keys();
        do_addr_op(2, 4'h1);
    endtask

    task automatic test_hold_through_reset;
        int w0;
        logic seen_busy;
        seen_busy = 1'b0;
        KEY[0] = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if (a !== 4'h0 || din !== 8'h00 || we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: a=%h din=%h we=%b busy=%b, want 0 00 0 0", a, din, we, busy);
        end
        w0 = wr_count;
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        vectors++;
        if (wr_count !== w0 || seen_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_key_event: writes=%0d busy_seen=%b, want 0 0", wr_count - w0, seen_busy);
        end
        release_keys();
        do_data_op(0, 4'h0, 8'h02);
    endtask

    task automatic test_reset_in_wr;
        int n;
        int w0;
        w0 = wr_count;
        KEY[1] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (we !== 1'b1 && n < 40);
        vectors++;
        if (we !== 1'b1 || din !== 8'h01) begin
            errors++;
            $display("FAIL reach_wr: we=%b din=%h, want 1 01", we, din);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (we !== 1'b0 || busy !== 1'b0 || a !== 4'h0) begin
            errors++;
            $display("FAIL reset_in_wr: we=%b busy=%b a=%h, want 0 0 0", we, busy, a);
        end
        repeat (2) tick();
        KEY = 4'hF;
        reset = 1'b0;
        repeat (14) tick();
        vectors++;
        if (wr_count - w0 !== 1 || mem[0] !== 8'h01) begin
            errors++;
            $display("FAIL wr_under_reset: writes=%0d mem0=%h, want 1 01", wr_count - w0, mem[0]);
        end
    endtask

`ifdef MEM_EDIT_AUTOREPEAT_EN
    task automatic test_autorepeat;
        int n;
        int cnt;
        int wj [8];
        logic [7:0] wd [8];
        int        exp_j [4];
        logic [7:0] exp_d [4];
        exp_j[0] = 1;     exp_j[1] = 24;    exp_j[2] = 44;    exp_j[3] = 64;
        exp_d[0] = 8'hFF; exp_d[1] = 8'h00; exp_d[2] = 8'h01; exp_d[3] = 8'h02;
        mem[0] = 8'hFE;
        repeat (2) tick();
        KEY[0] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (busy !== 1'b1 && n < 40);
        cnt = 0;
        for (int j = 1; j < 70; j++) begin
            tick();
            if (we === 1'b1) begin
                if (cnt < 8) begin wj[cnt] = j; wd[cnt] = din; end
                cnt++;
            end
        end
        vectors++;
        if (cnt !== 4) begin errors++; $display("FAIL repeat_count: got %0d pulses, want 4", cnt); end
        for (int i = 0; i < 4; i++) begin
            if (i < cnt) begin
                vectors++;
                if (wj[i] !== exp_j[i] || wd[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL repeat_%0d: at E+%0d din=%h, want E+%0d din=%h",
                             i, wj[i] + 1, wd[i], exp_j[i] + 1, exp_d[i]);
                end
            end
        end
        release_keys();
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_data_inc();
        test_addr_wrap_and_dec();
        test_bounce();
        test_multi_key();
        test_hold_through_reset();
        test_reset_in_wr();
`ifdef MEM_EDIT_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
